// File: rtl/aes_pkg.sv
// Shared AES helpers: GF(2^8) arithmetic over x^8+x^4+x^3+x+1 and the
// InvMixColumns control states. Encrypt-side MixColumns reuses xtime from here.
package aes_pkg;

    localparam logic [7:0] AES_POLY_RED = 8'h1b;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } imc_state_t;

    // Reduction depends only on the operand's own top bit.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        xtime = {x[6:0], 1'b0} ^ (x[7] ? AES_POLY_RED : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul09(input logic [7:0] x);
        logic [7:0] x8;
        x8 = xtime(xtime(xtime(x)));
        gf_mul09 = x8 ^ x;
    endfunction

    function automatic logic [7:0] gf_mul0b(input logic [7:0] x);
        logic [7:0] x2;
        logic [7:0] x8;
        x2 = xtime(x);
        x8 = xtime(xtime(x2));
        gf_mul0b = x8 ^ x2 ^ x;
    endfunction

    function automatic logic [7:0] gf_mul0d(input logic [7:0] x);
        logic [7:0] x4;
        logic [7:0] x8;
        x4 = xtime(xtime(x));
        x8 = xtime(x4);
        gf_mul0d = x8 ^ x4 ^ x;
    endfunction

    function automatic logic [7:0] gf_mul0e(input logic [7:0] x);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        gf_mul0e = x8 ^ x4 ^ x2;
    endfunction

endpackage

// File: rtl/inv_mix_single_column.sv
// Combinational InvMixColumns for one 4-byte column; byte 0 sits in [31:24].
module inv_mix_single_column
    import aes_pkg::*;
(
    input  logic [31:0] column,
    output logic [31:0] result
);

    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    logic [7:0] b3;

    assign b0 = column[31:24];
    assign b1 = column[23:16];
    assign b2 = column[15:8];
    assign b3 = column[7:0];

    // Rows of the circulant matrix {0e,0b,0d,09}
    assign result[31:24] = gf_mul0e(b0) ^ gf_mul0b(b1) ^ gf_mul0d(b2) ^ gf_mul09(b3);
    assign result[23:16] = gf_mul09(b0) ^ gf_mul0e(b1) ^ gf_mul0b(b2) ^ gf_mul0d(b3);
    assign result[15:8]  = gf_mul0d(b0) ^ gf_mul09(b1) ^ gf_mul0e(b2) ^ gf_mul0b(b3);
    assign result[7:0]   = gf_mul0b(b0) ^ gf_mul0d(b1) ^ gf_mul09(b2) ^ gf_mul0e(b3);

endmodule

// File: rtl/inv_mix_columns.sv
// Iterative InvMixColumns: one shared column unit rewrites the state register
// in place, one column per cycle, then holds the result until accepted.
module inv_mix_columns
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    imc_state_t   state;
    logic [1:0]   col;
    logic [127:0] data;
    logic [31:0]  col_in;
    logic [31:0]  col_out;

    always_comb begin
        col_in = data[127:96];
        case (col)
            2'd0: col_in = data[127:96];
            2'd1: col_in = data[95:64];
            2'd2: col_in = data[63:32];
            2'd3: col_in = data[31:0];
            default: col_in = data[127:96];
        endcase
    end

    inv_mix_single_column u_column (
        .column (col_in),
        .result (col_out)
    );

    // out_ready reaches in_ready only in DONE, enabling same-edge handover.
    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign out_valid = (state == DONE);
    assign out_data  = data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            col   <= 2'd0;
            data  <= 128'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data  <= in_data;
                        col   <= 2'd0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    case (col)
                        2'd0: data[127:96] <= col_out;
                        2'd1: data[95:64]  <= col_out;
                        2'd2: data[63:32]  <= col_out;
                        2'd3: data[31:0]   <= col_out;
                        default: data[127:96] <= col_out;
                    endcase
                    col <= col + 2'd1;
                    if (col == 2'd3) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        if (in_valid) begin
                            data  <= in_data;
                            col   <= 2'd0;
                            state <= BUSY;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    col   <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inv_mix_columns.sv
// Directed-vector bench for inv_mix_columns using FIPS-197 reference columns.
module tb_inv_mix_columns;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    int checks;
    int failures;

    localparam logic [127:0] FIPS_IN  = 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8;
    localparam logic [127:0] FIPS_OUT = 128'hdb135345_f20a225c_d4d4d4d5_2d26314c;

    inv_mix_columns dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a block and returns once the accept edge has passed.
    task automatic send_block(input logic [127:0] d, output bit ok);
        ok       = 1'b0;
        in_data  = d;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_out_valid(input int budget, output int cycles);
        cycles = 0;
        while (!out_valid && cycles < budget) begin
            tick();
            cycles++;
        end
        if (!out_valid) cycles = -1;
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = 128'd0;
        out_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        checks++;
        if (out_data !== 128'd0) begin
            failures++;
            $display("[TB] FAIL reset_out_data: got %h expected 0", out_data);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single_column();
        bit ok;
        int cyc;
        send_block({32'h8e4da1bc, 96'd0}, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL single_accept: got no accept expected accept");
        end
        wait_out_valid(20, cyc);
        checks++;
        if (cyc != 4) begin
            failures++;
            $display("[TB] FAIL single_latency: got %0d expected 4", cyc);
        end
        checks++;
        if (out_data !== {32'hdb135345, 96'd0}) begin
            failures++;
            $display("[TB] FAIL single_data: got %h expected %h", out_data, {32'hdb135345, 96'd0});
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL single_release: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready);
        end
    endtask

    task automatic test_fips_vector();
        bit ok;
        int cyc;
        send_block(FIPS_IN, ok);
        wait_out_valid(20, cyc);
        checks++;
        if (!ok || cyc != 4) begin
            failures++;
            $display("[TB] FAIL fips_handshake: got ok=%0d cycles=%0d expected ok=1 cycles=4", ok, cyc);
        end
        checks++;
        if (out_data !== FIPS_OUT) begin
            failures++;
            $display("[TB] FAIL fips_data: got %h expected %h", out_data, FIPS_OUT);
        end
        tick();
    endtask

    task automatic test_fixed_points();
        logic [127:0] vec [4];
        bit ok;
        int cyc;
        vec[0] = {4{32'hc6c6c6c6}};
        vec[1] = {4{32'h01010101}};
        vec[2] = 128'd0;
        vec[3] = {16{8'hff}};
        for (int i = 0; i < 4; i++) begin
            send_block(vec[i], ok);
            wait_out_valid(20, cyc);
            checks++;
            if (cyc != 4 || out_data !== vec[i]) begin
                failures++;
                $display("[TB] FAIL fixed_point_%0d: got %h (cycles %0d) expected %h (cycles 4)", i, out_data, cyc, vec[i]);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int cyc;
        out_ready = 1'b0;
        send_block(FIPS_IN, ok);
        in_data = 128'hdeadbeef_01234567_89abcdef_cafef00d;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (in_ready !== 1'b0) begin
                failures++;
                $display("[TB] FAIL busy_in_ready_%0d: got %b expected 0", i, in_ready);
            end
            tick();
        end
        wait_out_valid(20, cyc);
        checks++;
        if (cyc < 0) begin
            failures++;
            $display("[TB] FAIL bp_out_valid: got timeout expected out_valid");
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== FIPS_OUT) begin
                failures++;
                $display("[TB] FAIL bp_hold_%0d: got valid=%b ready=%b data=%h expected valid=1 ready=0 data=%h",
                         i, out_valid, in_ready, out_data, FIPS_OUT);
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL bp_release: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int cyc;
        out_ready = 1'b1;
        send_block(FIPS_IN, ok);
        in_valid = 1'b1;
        wait_out_valid(20, cyc);
        checks++;
        if (cyc != 4 || out_data !== FIPS_OUT) begin
            failures++;
            $display("[TB] FAIL b2b_first: got %h (cycles %0d) expected %h (cycles 4)", out_data, cyc, FIPS_OUT);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL b2b_in_ready: got %b expected 1", in_ready);
        end
        in_data = {32'h8e4da1bc, 96'd0};
        tick();
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        checks++;
        if (cyc != 5) begin
            failures++;
            $display("[TB] FAIL b2b_spacing: got %0d expected 5", cyc);
        end
        checks++;
        if (out_data !== {32'hdb135345, 96'd0}) begin
            failures++;
            $display("[TB] FAIL b2b_second: got %h expected %h", out_data, {32'hdb135345, 96'd0});
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL b2b_idle: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int cyc;
        send_block(FIPS_IN, ok);
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 128'd0) begin
            failures++;
            $display("[TB] FAIL mid_reset: got valid=%b ready=%b data=%h expected valid=0 ready=1 data=0",
                     out_valid, in_ready, out_data);
        end
        tick();
        rst = 1'b1;
        tick();
        send_block(FIPS_IN, ok);
        wait_out_valid(20, cyc);
        checks++;
        if (cyc != 4 || out_data !== FIPS_OUT) begin
            failures++;
            $display("[TB] FAIL post_reset: got %h (cycles %0d) expected %h (cycles 4)", out_data, cyc, FIPS_OUT);
        end
        tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single_column();
        test_fips_vector();
        test_fixed_points();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
